// File: rtl/serial_tx_tick_pkg.sv
// Shared types and constants for the divided-clock serial transmitter.
package serial_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } tx_state_e;

    localparam logic IDLE_LEVEL = 1'b1;

    // Tick periods on the line for one frame; the DONE cycle is extra.
    function automatic int unsigned frame_ticks(input int unsigned data_w,
                                                 input int unsigned stop_bits,
                                                 input bit          parity_en);
        return 1 + data_w + stop_bits + (parity_en ? 1 : 0);
    endfunction

endpackage

// File: rtl/serial_tx_tick_if.sv
// Parallel word handshake into the serial transmitter.
interface serial_tx_tick_if #(
    parameter int unsigned DATA_W = 8
) ();

    logic [DATA_W-1:0] data_i;
    logic              valid_i;
    logic              ready_o;

    modport master (output data_i, output valid_i, input ready_o);
    modport slave  (input data_i, input valid_i, output ready_o);

endinterface

// File: rtl/serial_tx_tick_edge_detect.sv
// Rising-edge tick from a divided clock that is already registered in the clk_i domain.
module tick_edge_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clk_div_i,
    output logic tick_c
);

    logic clk_div_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clk_div_q <= 1'b0;
        end else begin
            clk_div_q <= clk_div_i;
        end
    end

    assign tick_c = clk_div_i & ~clk_div_q;

endmodule

// File: rtl/serial_tx_tick.sv
// UART-style serializer paced by divided-clock ticks.
// Define SERIAL_TX_PARITY_EN to insert an even-parity symbol after the data bits.
module serial_tx_tick
    import serial_tx_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned STOP_BITS = 1,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clk_div_i,
    serial_tx_tick_if.slave         bus,
    output logic                    tx_o,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    tx_state_e         state_q;
    logic [DATA_W-1:0] shreg_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic              stop_cnt_q;
    logic              tx_q;
    logic              ready_q;
    logic              busy_q;
    logic              done_q;
    logic              tick_c;
`ifdef SERIAL_TX_PARITY_EN
    logic              par_q;
`endif

    tick_edge_detect u_tick (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clk_div_i (clk_div_i),
        .tick_c    (tick_c)
    );

    // Frame sequencer; every line change is gated by tick_c so the bit rate follows the divider.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= IDLE_LEVEL;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // A tick coinciding with accept is deliberately skipped.
                    if (bus.valid_i && ready_q) begin
                        shreg_q <= bus.data_i;
`ifdef SERIAL_TX_PARITY_EN
                        par_q   <= ^bus.data_i;
`endif
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= START;
                    end
                end

                START: begin
                    if (tick_c) begin
                        tx_q      <= 1'b0;
                        bit_cnt_q <= '0;
                        state_q   <= DATA;
                    end
                end

                DATA: begin
                    if (tick_c) begin
                        if (bit_cnt_q == CNT_W'(DATA_W)) begin
`ifdef SERIAL_TX_PARITY_EN
                            tx_q       <= par_q;
                            state_q    <= PARITY;
`else
                            tx_q       <= IDLE_LEVEL;
                            stop_cnt_q <= 1'b0;
                            state_q    <= STOP;
`endif
                        end else begin
                            if (LSB_FIRST) begin
                                tx_q    <= shreg_q[0];
                                shreg_q <= shreg_q >> 1;
                            end else begin
                                tx_q    <= shreg_q[DATA_W-1];
                                shreg_q <= shreg_q << 1;
                            end
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        end
                    end
                end

`ifdef SERIAL_TX_PARITY_EN
                PARITY: begin
                    if (tick_c) begin
                        tx_q       <= IDLE_LEVEL;
                        stop_cnt_q <= 1'b0;
                        state_q    <= STOP;
                    end
                end
`endif

                STOP: begin
                    // Each tick closes one stop period; the last one closes the frame.
                    if (tick_c) begin
                        if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            stop_cnt_q <= stop_cnt_q + 1'b1;
                        end
                    end
                end

                DONE: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    tx_q    <= IDLE_LEVEL;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready_o = ready_q;
    assign tx_o        = tx_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_serial_tx_tick.sv
// Directed bench for serial_tx_tick: divide-by-4 tick source, 8N1 frames (8E1 with SERIAL_TX_PARITY_EN).
module tb_serial_tx_tick;

`ifdef SERIAL_TX_PARITY_EN
    localparam int NSYM = 11;
`else
    localparam int NSYM = 10;
`endif
    localparam int DONE_AT = 4 * NSYM;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_div = 1'b0;
    logic       div_en = 1'b1;
    logic [1:0] div_cnt = 2'd0;
    logic       tx_o, busy_o, done_o;

    int compared = 0;
    int mismatched = 0;

    serial_tx_tick_if #(.DATA_W(8)) bus ();

    serial_tx_tick #(.DATA_W(8), .STOP_BITS(1), .LSB_FIRST(1'b1)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .clk_div_i (clk_div),
        .bus       (bus),
        .tx_o      (tx_o),
        .busy_o    (busy_o),
        .done_o    (done_o)
    );

    always #5 clk = ~clk;

    // Registered divide-by-4 clock; holding div_en low freezes it.
    always @(posedge clk) begin
        if (div_en) begin
            div_cnt <= div_cnt + 2'd1;
            clk_div <= (div_cnt == 2'd1) || (div_cnt == 2'd2);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_sym(input logic [7:0] w, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return w[k-1];
`ifdef SERIAL_TX_PARITY_EN
        if (k == 9) return ^w;
`endif
        return 1'b1;
    endfunction

    task automatic idle_check(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            chk("idle_tx", tx_o, 1);
            chk("idle_ready", bus.ready_o, 1);
            chk("idle_busy", busy_o, 0);
            chk("idle_done", done_o, 0);
        end
    endtask

    // Entered on a negedge after accept; checks samples 0..last counted from the start bit.
    task automatic run_frame(input logic [7:0] w, input int last, input int freeze_at);
        int n = 0;
        while (tx_o !== 1'b0 && n < 12) begin
            @(negedge clk);
            n++;
        end
        chk("start_bit", tx_o, 0);
        for (int i = 0; i <= last; i++) begin
            if (i > 0) @(negedge clk);
            if (i < DONE_AT) begin
                chk("tx_sym", tx_o, exp_sym(w, i / 4));
                chk("ready_low", bus.ready_o, 0);
                chk("busy_high", busy_o, 1);
                chk("done_low", done_o, 0);
            end else if (i == DONE_AT) begin
                chk("done_pulse", done_o, 1);
                chk("tx_end_idle", tx_o, 1);
            end else begin
                chk("done_clear", done_o, 0);
                chk("ready_back", bus.ready_o, 1);
                chk("busy_clear", busy_o, 0);
            end
            if (i == freeze_at) begin
                div_en = 1'b0;
                repeat (30) begin
                    @(negedge clk);
                    chk("tx_frozen", tx_o, exp_sym(w, i / 4));
                    chk("done_frozen", done_o, 0);
                end
                div_en = 1'b1;
            end
        end
    endtask

    task automatic send(input logic [7:0] w);
        chk("ready_before_send", bus.ready_o, 1);
        bus.data_i  = w;
        bus.valid_i = 1'b1;
        @(negedge clk);
        bus.valid_i = 1'b0;
    endtask

    initial begin
        bus.data_i  = 8'h00;
        bus.valid_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx_o, 1);
        chk("rst_ready", bus.ready_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        rst = 1'b0;
        idle_check(20);

        // 0xA5: 0,1,0,1,0,0,1,0,1,1 on the line
        send(8'hA5);
        run_frame(8'hA5, DONE_AT + 1, -1);

        // Back-to-back with valid held high; the 0xFF offered mid-frame must wait.
        chk("ready_before_b2b", bus.ready_o, 1);
        bus.data_i  = 8'h00;
        bus.valid_i = 1'b1;
        @(negedge clk);
        bus.data_i  = 8'hFF;
        run_frame(8'h00, DONE_AT + 1, -1);
        @(negedge clk);
        bus.valid_i = 1'b0;
        run_frame(8'hFF, DONE_AT + 1, -1);
        idle_check(20);

        // Reset during d3 of 0x3C drops the frame
        send(8'h3C);
        run_frame(8'h3C, 17, -1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_tx", tx_o, 1);
        chk("midrst_ready", bus.ready_o, 1);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_done", done_o, 0);
        rst = 1'b0;
        idle_check(20);
        send(8'h3C);
        run_frame(8'h3C, DONE_AT + 1, -1);

        // Divider stalled for 30 cycles in the middle of d4 of 0x5A
        send(8'h5A);
        run_frame(8'h5A, DONE_AT + 1, 22);

        send(8'h07);
        run_frame(8'h07, DONE_AT + 1, -1);
        idle_check(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
